echo_meter: RTL and testbench

ECHO_METER -- requirements
Module: echo_meter

---
 rtl/hcsr04_pkg.sv | 10 +
 rtl/echo_sync.sv | 15 +
 rtl/echo_meter.sv | 107 ++++++++++
 tb/tb_echo_meter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/hcsr04_pkg.sv
// hcsr04_pkg: shared widths, conversion constants and FSM state type for the HC-SR04 echo meter.
package hcsr04_pkg;
  localparam int TIME_W   = 16;
  localparam int DIST_W   = 13;
  localparam int PROD_W   = 30;
  localparam int SUM_W    = DIST_W + 2;
  localparam int K_MM_DEF = 11239;
  localparam int K_SHIFT  = 16;
  typedef enum logic [2:0] {IDLE, WAIT_RISE, MEASURE, DONE, TIMEOUT} state_e;
endpackage

// File: rtl/echo_sync.sv
// echo_sync: 2-FF synchronizer plus delay FF, with rise/fall detection of the raw echo pin.
module echo_sync (
  input  logic clk_us,
  input  logic rstn,
  input  logic echo_i,
  output logic rise_o,
  output logic fall_o
);
  logic meta_q, sync_q, dly_q;
  always_ff @(posedge clk_us or negedge rstn)
    if (!rstn) {meta_q, sync_q, dly_q} <= '0;
    else {meta_q, sync_q, dly_q} <= {echo_i, meta_q, sync_q};
  assign rise_o = sync_q & ~dly_q;
  assign fall_o = ~sync_q & dly_q;
endmodule

// File: rtl/echo_meter.sv
// echo_meter: HC-SR04 echo high-time meter with millimetre conversion.
// Define ECHO_METER_AVG_EN to report the mean of the last four distances.
module echo_meter
  import hcsr04_pkg::*;
#(
  parameter int unsigned TIMEOUT_US = 30000,
  parameter int unsigned K_MM       = K_MM_DEF
) (
  input  logic              clk_us,
  input  logic              rstn,
  input  logic              trig,
  input  logic              echo,
  output logic [TIME_W-1:0] echo_us,
  output logic [DIST_W-1:0] dist_mm,
  output logic              dist_valid,
  output logic              timeout,
  output logic              busy
);
  state_e            state_q, state_d;
  logic [TIME_W-1:0] cnt_q, cnt_d, echo_us_q, echo_us_d;
  logic [DIST_W-1:0] dist_mm_q, raw_mm;
  logic [PROD_W-1:0] prod;
  logic              trig_q, trig_fall, rise, fall, at_lim, dist_valid_q, timeout_q;

  echo_sync u_sync (.clk_us(clk_us), .rstn(rstn), .echo_i(echo), .rise_o(rise), .fall_o(fall));

  assign trig_fall = trig_q & ~trig;
  assign at_lim    = cnt_q == TIME_W'(TIMEOUT_US - 1);
  assign prod      = PROD_W'(echo_us_q) * PROD_W'(K_MM);
  assign raw_mm    = DIST_W'(prod >> K_SHIFT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    echo_us_d = echo_us_q;
    case (state_q)
      IDLE: if (trig_fall) begin
        state_d = WAIT_RISE;
        cnt_d   = '0;
      end
      WAIT_RISE: begin
        cnt_d   = (trig_fall || rise) ? '0 : cnt_q + 16'd1;
        state_d = trig_fall ? WAIT_RISE : rise ? MEASURE : at_lim ? TIMEOUT : WAIT_RISE;
      end
      MEASURE: begin
        cnt_d     = trig_fall ? '0 : cnt_q + 16'd1;
        echo_us_d = (!trig_fall && fall) ? cnt_q + 16'd1 : echo_us_q;
        state_d   = trig_fall ? WAIT_RISE : fall ? DONE : at_lim ? TIMEOUT : MEASURE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_us or negedge rstn)
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      trig_q    <= 1'b0;
      echo_us_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      trig_q    <= trig;
      echo_us_q <= echo_us_d;
      timeout_q <= state_q == TIMEOUT;
    end

`ifdef ECHO_METER_AVG_EN
  logic [3:0][DIST_W-1:0] hist_q;
  logic                   primed_q, pend_q;
  logic [SUM_W-1:0]       sum;
  assign sum = SUM_W'(hist_q[0]) + SUM_W'(hist_q[1]) + SUM_W'(hist_q[2]) + SUM_W'(hist_q[3]);
  // History is written in DONE; the mean is published one cycle later from the updated history.
  always_ff @(posedge clk_us or negedge rstn)
    if (!rstn) begin
      hist_q       <= '0;
      primed_q     <= 1'b0;
      pend_q       <= 1'b0;
      dist_mm_q    <= '0;
      dist_valid_q <= 1'b0;
    end else begin
      pend_q       <= state_q == DONE;
      dist_valid_q <= pend_q;
      if (pend_q) dist_mm_q <= DIST_W'(sum >> 2);
      if (state_q == DONE) begin
        primed_q <= 1'b1;
        hist_q   <= primed_q ? {hist_q[2:0], raw_mm} : {4{raw_mm}};
      end
    end
`else
  always_ff @(posedge clk_us or negedge rstn)
    if (!rstn) begin
      dist_mm_q    <= '0;
      dist_valid_q <= 1'b0;
    end else begin
      dist_valid_q <= state_q == DONE;
      if (state_q == DONE) dist_mm_q <= raw_mm;
    end
`endif

  assign echo_us    = echo_us_q;
  assign dist_mm    = dist_mm_q;
  assign dist_valid = dist_valid_q;
  assign timeout    = timeout_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_echo_meter.sv
// tb_echo_meter: scoreboard bench for echo_meter with a spec-level reference model.
module tb_echo_meter;
  localparam int TO = 30000;

  typedef struct {
    bit is_to;
    int us;
    int mm;
    int lo;
    int hi;
  } exp_t;

  logic        clk = 1'b0, rstn = 1'b0, trig = 1'b0, echo = 1'b0;
  logic [15:0] echo_us;
  logic [12:0] dist_mm;
  logic        dist_valid, timeout, busy;

  int   checks = 0, errors = 0, cyc = 0, tfall = 0;
  int   last_us = 0, last_mm = 0;
  int   hist[4];
  bit   primed = 1'b0;
  exp_t sb[$];
  exp_t m;

  echo_meter dut (
    .clk_us(clk), .rstn(rstn), .trig(trig), .echo(echo),
    .echo_us(echo_us), .dist_mm(dist_mm), .dist_valid(dist_valid),
    .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic chk_win(string n, int act, int lo, int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got cycle %0d expected %0d..%0d", n, act, lo, hi);
    end
  endtask

  function automatic int dist_of(int w);
    longint p = longint'(w) * 64'd11239;
    return int'((p % (64'd1 << 30)) >> 16);
  endfunction

  task automatic model_reset();
    last_us = 0;
    last_mm = 0;
    primed  = 1'b0;
  endtask

  task automatic model_valid(int w, int c);
    exp_t e;
    int raw, mm, lat;
    raw = dist_of(w);
`ifdef ECHO_METER_AVG_EN
    if (!primed) hist = '{raw, raw, raw, raw};
    else hist = '{hist[1], hist[2], hist[3], raw};
    primed = 1'b1;
    mm  = (hist[0] + hist[1] + hist[2] + hist[3]) / 4;
    lat = 5;
`else
    mm  = raw;
    lat = 4;
`endif
    last_us = w;
    last_mm = mm;
    e.is_to = 1'b0; e.us = w; e.mm = mm; e.lo = c + lat; e.hi = c + lat;
    sb.push_back(e);
  endtask

  task automatic model_timeout(int lo, int hi);
    exp_t e;
    e.is_to = 1'b1; e.us = last_us; e.mm = last_mm; e.lo = lo; e.hi = hi;
    sb.push_back(e);
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic trig_pulse();
    @(negedge clk) trig = 1'b1;
    repeat (15) @(negedge clk);
    trig  = 1'b0;
    tfall = cyc;
  endtask

  task automatic echo_pulse(int w);
    @(negedge clk) echo = 1'b1;
    repeat (w) @(negedge clk);
    echo = 1'b0;
    model_valid(w, cyc);
  endtask

  task automatic measure(int w);
    trig_pulse();
    idle(2);
    chk("busy", busy, 1);
    echo_pulse(w);
    idle(12);
  endtask

  always @(negedge clk)
    if (rstn && (dist_valid || timeout)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {dist_valid, timeout}, 0);
      end else begin
        m = sb.pop_front();
        chk("pulse_kind", {30'd0, dist_valid, timeout}, m.is_to ? 1 : 2);
        chk("echo_us", echo_us, m.us);
        chk("dist_mm", dist_mm, m.mm);
        chk_win("pulse_cycle", cyc, m.lo, m.hi);
      end
    end

  initial begin
    idle(3);
    chk("reset_outputs", {echo_us, dist_mm, dist_valid, timeout, busy}, 0);
    rstn = 1'b1;
    model_reset();
    idle(300);
    chk("quiet_after_reset", {echo_us, dist_mm, dist_valid, timeout, busy}, 0);
    measure(5832);
    measure(5832);
    measure(5832);
    measure(2916);
    measure(1);
    trig_pulse();
    idle(2);
    @(negedge clk) echo = 1'b1;
    idle(100);
    trig_pulse();
    echo = 1'b0;
    idle(20);
    echo_pulse(777);
    idle(12);
    for (int i = 0; i < 4; i++) measure($urandom_range(2, 400));
    trig_pulse();
    model_timeout(tfall + TO, tfall + TO + 4);
    idle(TO + 20);
    trig_pulse();
    idle(2);
    @(negedge clk) echo = 1'b1;
    model_timeout(cyc + TO, cyc + TO + 6);
    idle(TO + 100);
    echo = 1'b0;
    idle(20);
    trig_pulse();
    idle(2);
    @(negedge clk) echo = 1'b1;
    idle(1000);
    rstn = 1'b0;
    #1;
    chk("async_reset_outputs", {echo_us, dist_mm, dist_valid, timeout, busy}, 0);
    model_reset();
    echo = 1'b0;
    idle(3);
    rstn = 1'b1;
    idle(5);
    measure(2916);
    idle(20);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
